// File: rtl/uart_frame_parser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_frame_parser
//  Purpose  : Decodes SYNC/HI/LO/CHK byte frames from a UART receiver into a
//             16-bit price, with checksum and inter-byte timeout error reporting.
//  Revision : 1.0  initial release
// ============================================================================
module uart_frame_parser #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 312_500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] price,
    output logic        price_valid,
    output logic        frame_err,
    output logic [7:0]  err_count
);

    localparam int c_tmo_w = (TIMEOUT_CLKS < 1) ? 1 : $clog2(TIMEOUT_CLKS + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_max = c_tmo_w'(TIMEOUT_CLKS);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_get_hi  = 2'd1;
    localparam logic [1:0] c_get_lo  = 2'd2;
    localparam logic [1:0] c_get_chk = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_rx_valid_q;
    logic [7:0]         r_hi;
    logic [7:0]         r_lo;
    logic [c_tmo_w-1:0] r_tmo;
    logic [15:0]        r_price;
    logic               r_price_valid;
    logic               r_frame_err;
    logic [7:0]         r_err_count;

    logic               w_accept;
    logic               w_timeout;
    logic               w_chk_ok;
    logic               w_chk_bad;

    // Rising edge of the strobe only; a long strobe counts as one byte.
    assign w_accept = rx_valid & ~r_rx_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (w_accept && (rx_data == SYNC_BYTE)) w_state_nxt = c_get_hi;
            end
            c_get_hi: begin
                if (w_accept)       w_state_nxt = c_get_lo;
                else if (w_timeout) w_state_nxt = c_idle;
            end
            c_get_lo: begin
                if (w_accept)       w_state_nxt = c_get_chk;
                else if (w_timeout) w_state_nxt = c_idle;
            end
            c_get_chk: begin
                if (w_accept || w_timeout) w_state_nxt = c_idle;
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    // An acceptance in the same cycle the counter expires keeps the frame alive.
    always_comb begin
        w_timeout = (r_state != c_idle) && !w_accept && (r_tmo == c_tmo_max);
        w_chk_ok  = (r_state == c_get_chk) && w_accept && (rx_data == (r_hi ^ r_lo));
        w_chk_bad = (r_state == c_get_chk) && w_accept && (rx_data != (r_hi ^ r_lo));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_valid_q  <= 1'b1;
            r_hi          <= 8'h00;
            r_lo          <= 8'h00;
            r_tmo         <= '0;
            r_price       <= 16'h0000;
            r_price_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_err_count   <= 8'h00;
        end else begin
            r_rx_valid_q  <= rx_valid;
            r_price_valid <= w_chk_ok;
            r_frame_err   <= w_chk_bad | w_timeout;

            if (w_accept && (r_state == c_get_hi)) r_hi <= rx_data;
            if (w_accept && (r_state == c_get_lo)) r_lo <= rx_data;

            if ((r_state == c_idle) || w_accept) begin
                r_tmo <= '0;
            end else if (r_tmo != c_tmo_max) begin
                r_tmo <= r_tmo + 1'b1;
            end

            if (w_chk_ok) r_price <= {r_hi, r_lo};

            if ((w_chk_bad || w_timeout) && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign price       = r_price;
    assign price_valid = r_price_valid;
    assign frame_err   = r_frame_err;
    assign err_count   = r_err_count;

endmodule
`default_nettype wire

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 Parameter TIMEOUT_CLKS, default 312_500, max idle clocks between bytes inside a frame (~3 byte times at 9600 baud / 100 MHz).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rx_data  input  8  received byte from the UART receiver.
REQ-006 rx_valid  input  1  byte-ready strobe from the UART receiver; may be high for one or more cycles per byte.
REQ-007 price  output  16  last valid decoded price, held between frames.
REQ-008 price_valid  output  1  one-cycle pulse when price is updated.
REQ-009 frame_err  output  1  one-cycle pulse on checksum mismatch or timeout.
REQ-010 err_count  output  8  saturating count of frame_err pulses.

Function
REQ-011 Frame format, in order: SYNC_BYTE, PRICE_HI, PRICE_LO, CHK, where valid CHK = PRICE_HI XOR PRICE_LO.
REQ-012 Byte acceptance: register rx_valid into rx_valid_q; accept rx_data in a cycle where rx_valid=1 and rx_valid_q=0 (rising edge only); a held-high rx_valid yields one acceptance.
REQ-013 FSM states: IDLE, GET_HI, GET_LO, GET_CHK.
REQ-014 IDLE: accepted byte == SYNC_BYTE -> GET_HI; any other byte ignored, no error, stay IDLE.
REQ-015 GET_HI: accepted byte stored as hi -> GET_LO; a SYNC_BYTE value here is data, no resync.
REQ-016 GET_LO: accepted byte stored as lo -> GET_CHK.
REQ-017 GET_CHK: accepted byte == hi XOR lo -> price <= {hi,lo}, price_valid=1 next cycle, -> IDLE.
REQ-018 GET_CHK: accepted byte != hi XOR lo -> price unchanged, frame_err=1 next cycle, err_count+1, -> IDLE.
REQ-019 Latency: price_valid / frame_err asserted in the cycle immediately after the acceptance cycle of the CHK byte; high exactly one cycle.
REQ-020 Timeout counter: cleared on every accepted byte and in IDLE; increments each cycle in GET_HI/GET_LO/GET_CHK; width sufficient for TIMEOUT_CLKS without wrap.
REQ-021 Timeout: counter reaching TIMEOUT_CLKS with no acceptance that cycle -> IDLE, frame_err pulse next cycle, err_count+1, partial bytes discarded.
REQ-022 Simultaneous acceptance and timeout in the same cycle: acceptance wins, no timeout error.
REQ-023 err_count saturates at 8'hFF; further errors still pulse frame_err.
REQ-024 price_valid and frame_err never asserted in the same cycle.

Reset
REQ-025 rst=1 at a clock edge: state IDLE, price=0, price_valid=0, frame_err=0, err_count=0, timeout counter=0, hi/lo=0.
REQ-026 rx_valid_q resets to 1, so an rx_valid held high through reset release is not accepted.
REQ-027 Reset mid-frame abandons the frame with no frame_err and no err_count change.

Verification
REQ-028 Bytes A5,12,34,26 (one-cycle strobes) -> price=16'h1234, price_valid one cycle after CHK acceptance, err_count=0.
REQ-029 Bytes A5,12,34,00 -> frame_err one pulse, err_count=1, price keeps prior value, next frame A5,00,01,01 -> price=16'h0001.
REQ-030 Bytes 00,FF,A5,A5,00,A5 with rx_valid held high 3 cycles each -> price=16'hA500, single price_valid, no frame_err.
REQ-031 A5,12 then silence TIMEOUT_CLKS cycles -> frame_err one pulse, state IDLE; following A5,12,34,26 decodes normally; with TIMEOUT_CLKS=16 and a byte arriving exactly at count 16 -> no error.
REQ-032 260 consecutive bad-CHK frames -> err_count=8'hFF, 260 frame_err pulses.
REQ-033 rst pulsed after A5,12 with rx_valid high across release -> no acceptance, outputs zero, next full frame decodes.
